// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : layer_compositor
//  Purpose  : N-layer priority pixel compositor with per-layer enable,
//             frame-synchronous blink and a 2-stage colour/blank pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    pixelx,
    input  logic [9:0]                    pixely,
    input  logic [NUM_LAYERS-1:0]         layer_visible,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [NUM_LAYERS-1:0]         blink_mask,
    input  logic [3*COLOR_W-1:0]          bg_color,
    input  logic [3*COLOR_W-1:0]          hl_color,
    input  logic                          highlight,
    output logic [COLOR_W-1:0]            vga_r,
    output logic [COLOR_W-1:0]            vga_g,
    output logic [COLOR_W-1:0]            vga_b,
    output logic                          blank,
    output logic                          sync,
    output logic                          blink_phase
);

    localparam int                c_RGB_W   = 3 * COLOR_W;
    localparam logic [9:0]        c_H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]        c_V_ACT   = 10'(V_ACTIVE);
    localparam logic [BLINK_LOG2:0] c_CNT_ONE = {{BLINK_LOG2{1'b0}}, 1'b1};

    logic                   w_active;
    logic                   w_eof;
    logic                   w_frame_inc;
    logic [NUM_LAYERS-1:0]  w_eff;
    logic [c_RGB_W-1:0]     w_sel;

    logic [BLINK_LOG2:0]    r_frame_cnt;
    logic                   r_eof_q;
    logic                   r_blink_phase;
    logic [c_RGB_W-1:0]     r_s1_color;
    logic                   r_s1_active;
    logic [c_RGB_W-1:0]     r_s2_color;
    logic                   r_s2_active;

    assign w_active    = (pixelx < c_H_ACT) && (pixely < c_V_ACT);
    assign w_eof       = (pixely == c_V_ACT) && (pixelx == 10'd0);
    // Edge detect so a held coordinate (divided pixel clock) counts once.
    assign w_frame_inc = w_eof && !r_eof_q;
    assign w_eff       = layer_visible & layer_enable
                         & ~(blink_mask & {NUM_LAYERS{r_blink_phase}});

    // Walk from lowest priority upward so layer 0 wins the final assignment.
    always_comb begin
        w_sel = highlight ? hl_color : bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_sel = layer_color[i*c_RGB_W +: c_RGB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_eof_q       <= 1'b0;
            r_blink_phase <= 1'b0;
        end else begin
            r_eof_q       <= w_eof;
            r_blink_phase <= r_frame_cnt[BLINK_LOG2];
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_color  <= '0;
            r_s1_active <= 1'b0;
            r_s2_color  <= '0;
            r_s2_active <= 1'b0;
        end else begin
            r_s1_color  <= w_sel;
            r_s1_active <= w_active;
            r_s2_color  <= r_s1_active ? r_s1_color : '0;
            r_s2_active <= r_s1_active;
        end
    end

    assign {vga_r, vga_g, vga_b} = r_s2_color;
    assign blank                 = r_s2_active;
    assign blink_phase           = r_blink_phase;
    assign sync                  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_compositor
//  Purpose  : Directed self-checking bench for layer_compositor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    logic        clk;
    logic        rst;
    logic [9:0]  pixelx;
    logic [9:0]  pixely;
    logic [3:0]  layer_visible;
    logic [95:0] layer_color;
    logic [3:0]  layer_enable;
    logic [3:0]  blink_mask;
    logic [23:0] bg_color;
    logic [23:0] hl_color;
    logic        highlight;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        blank;
    logic        sync;
    logic        blink_phase;

    int r_tests;
    int r_fails;

    layer_compositor #(
        .NUM_LAYERS (4),
        .COLOR_W    (8),
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .BLINK_LOG2 (1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pixelx        (pixelx),
        .pixely        (pixely),
        .layer_visible (layer_visible),
        .layer_color   (layer_color),
        .layer_enable  (layer_enable),
        .blink_mask    (blink_mask),
        .bg_color      (bg_color),
        .hl_color      (hl_color),
        .highlight     (highlight),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .blank         (blank),
        .sync          (sync),
        .blink_phase   (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One abbreviated frame: vertical-blank origin then back to a visible pixel.
    task automatic frame();
        pixelx = 10'd0;
        pixely = 10'd480;
        step(2);
        pixelx = 10'd10;
        pixely = 10'd10;
        step(2);
    endtask

    function automatic logic [31:0] rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_phase;
        r_tests       = 0;
        r_fails       = 0;
        rst           = 1'b1;
        pixelx        = 10'd5;
        pixely        = 10'd5;
        layer_visible = 4'b0001;
        layer_enable  = 4'b1111;
        blink_mask    = 4'b0000;
        layer_color   = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h123456};
        bg_color      = 24'hA5C4D4;
        hl_color      = 24'hA5F5D4;
        highlight     = 1'b0;

        // Reset and first-pixel latency
        step(1);
        check("rst_rgb", rgb(vga_r, vga_g, vga_b), 32'h0);
        check("rst_blank", {31'b0, blank}, 32'h0);
        check("rst_sync", {31'b0, sync}, 32'h1);
        step(2);
        check("rst_phase", {31'b0, blink_phase}, 32'h0);
        rst = 1'b0;
        step(1);
        check("lat1_rgb", rgb(vga_r, vga_g, vga_b), 32'h0);
        step(1);
        check("lat2_rgb", rgb(vga_r, vga_g, vga_b), 32'h123456);
        check("lat2_blank", {31'b0, blank}, 32'h1);

        // Priority and enable
        layer_visible = 4'b1110;
        step(2);
        check("prio_l1", rgb(vga_r, vga_g, vga_b), 32'hFF0000);
        layer_enable = 4'b1101;
        step(2);
        check("prio_l2", rgb(vga_r, vga_g, vga_b), 32'h00FF00);
        layer_enable  = 4'b1111;
        layer_visible = 4'b1000;
        step(2);
        check("prio_l3", rgb(vga_r, vga_g, vga_b), 32'h0000FF);

        // Background / highlight
        layer_visible = 4'b0000;
        step(2);
        check("bg", rgb(vga_r, vga_g, vga_b), 32'hA5C4D4);
        highlight = 1'b1;
        step(1);
        check("hl_lat1", rgb(vga_r, vga_g, vga_b), 32'hA5C4D4);
        step(1);
        check("hl_lat2", rgb(vga_r, vga_g, vga_b), 32'hA5F5D4);
        highlight = 1'b0;

        // Active-area boundaries
        layer_visible = 4'b0001;
        pixelx = 10'd640;
        pixely = 10'd10;
        step(2);
        check("x640_rgb", rgb(vga_r, vga_g, vga_b), 32'h0);
        check("x640_blank", {31'b0, blank}, 32'h0);
        pixelx = 10'd639;
        step(2);
        check("x639_rgb", rgb(vga_r, vga_g, vga_b), 32'h123456);
        check("x639_blank", {31'b0, blank}, 32'h1);
        pixelx = 10'd5;
        pixely = 10'd480;
        step(2);
        check("y480_blank", {31'b0, blank}, 32'h0);
        pixely = 10'd479;
        step(2);
        check("y479_blank", {31'b0, blank}, 32'h1);

        // Blink sweep over 8 frames; a disabled masked layer stays hidden.
        rst = 1'b1;
        step(1);
        rst           = 1'b0;
        blink_mask    = 4'b0011;
        layer_enable  = 4'b1101;
        layer_visible = 4'b0011;
        pixelx        = 10'd10;
        pixely        = 10'd10;
        step(2);
        check("blink_f0_rgb", rgb(vga_r, vga_g, vga_b), 32'h123456);
        for (int f = 1; f <= 8; f++) begin
            frame();
            exp_phase = ((f % 4) >= 2);
            check($sformatf("blink_f%0d_phase", f), {31'b0, blink_phase}, {31'b0, exp_phase});
            check($sformatf("blink_f%0d_rgb", f), rgb(vga_r, vga_g, vga_b),
                  exp_phase ? 32'hA5C4D4 : 32'h123456);
        end

        // Mid-frame reset with counter at 2 must clear phase and counter.
        frame();
        frame();
        check("pre_rst_phase", {31'b0, blink_phase}, 32'h1);
        pixelx = 10'd100;
        pixely = 10'd200;
        step(2);
        rst = 1'b1;
        step(1);
        check("mid_rst_rgb", rgb(vga_r, vga_g, vga_b), 32'h0);
        check("mid_rst_blank", {31'b0, blank}, 32'h0);
        check("mid_rst_phase", {31'b0, blink_phase}, 32'h0);
        rst = 1'b0;
        frame();
        check("post_rst_f1_phase", {31'b0, blink_phase}, 32'h0);
        frame();
        check("post_rst_f2_phase", {31'b0, blink_phase}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
